mem_slave: RTL and testbench

MEM_SLAVE -- requirements
Module: mem_slave

---
 rtl/mem_slave_pkg.sv | 19 +
 rtl/sp_ram.sv | 39 +++
 rtl/mem_slave.sv | 124 ++++++++++++
 tb/tb_mem_slave.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_slave_pkg.sv
// Shared types and constants for the mem_slave block.
// Holds the FSM state encoding and the command encoding.
package mem_slave_pkg;

    typedef enum logic [2:0] {
        IDLE_ADDR = 3'd0,
        GET_CMD   = 3'd1,
        GET_WR    = 3'd2,
        RD_WAIT   = 3'd3,
        RD_RESP   = 3'd4
    } state_e;

    localparam logic CMD_RD = 1'b0;
    localparam logic CMD_WR = 1'b1;

    // Wide enough for any read latency in 0..15.
    localparam int CNT_W = 4;

endpackage

// File: rtl/sp_ram.sv
// Single-port synchronous RAM with a registered read port.
// Array is never reset; only the read data register is.
module sp_ram
    import mem_slave_pkg::*;
#(
    parameter int A = 4,
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         we_i,
    input  logic         re_i,
    input  logic [A-1:0] addr_i,
    input  logic [W-1:0] wdata_i,
    output logic [W-1:0] rdata_o
);

    logic [W-1:0] mem_q [2**A];
    logic [W-1:0] rdata_q;

    // Storage array: written on enabled edges, contents survive reset.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    // Read register: loads only when asked, so it holds otherwise.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_slave.sv
// Memory slave with separate addr/cmd/wr/rd handshake phases.
// Moore FSM sequences the phases; storage lives in sp_ram.
module mem_slave
    import mem_slave_pkg::*;
#(
    parameter int A  = 4,
    parameter int W  = 8,
    parameter int RL = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [A-1:0] addr,
    input  logic         addr_val,
    output logic         addr_rdy,
    input  logic         cmd,
    input  logic         cmd_val,
    output logic         cmd_rdy,
    input  logic [W-1:0] wr_data,
    input  logic         wr_val,
    output logic         wr_rdy,
    output logic [W-1:0] rd_data,
    output logic         rd_val,
    input  logic         rd_rdy
);

    // Counter preload; a zero latency never uses the counter.
    localparam logic [CNT_W-1:0] RL_M1 =
        (RL > 0) ? CNT_W'(RL - 1) : '0;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [A-1:0]     addr_q, addr_d;
    // Low during reset and for one edge after, keeping rdy/val at 0.
    logic             live_q;
    logic             ram_we, ram_re;

    // State, counter, captured address and liveness flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE_ADDR;
            cnt_q   <= '0;
            addr_q  <= '0;
            live_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            live_q  <= 1'b1;
        end
    end

    // Next-state logic; a phase moves only when its val and rdy are both high.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        ram_we  = 1'b0;
        ram_re  = 1'b0;
        if (live_q) begin
            unique case (state_q)
                IDLE_ADDR: begin
                    if (addr_val) begin
                        addr_d  = addr;
                        state_d = GET_CMD;
                    end
                end
                GET_CMD: begin
                    if (cmd_val) begin
                        if (cmd == CMD_WR) begin
                            state_d = GET_WR;
                        end else if (RL == 0) begin
                            ram_re  = 1'b1;
                            state_d = RD_RESP;
                        end else begin
                            cnt_d   = RL_M1;
                            state_d = RD_WAIT;
                        end
                    end
                end
                GET_WR: begin
                    if (wr_val) begin
                        ram_we  = 1'b1;
                        state_d = IDLE_ADDR;
                    end
                end
                RD_WAIT: begin
                    if (cnt_q == '0) begin
                        ram_re  = 1'b1;
                        state_d = RD_RESP;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                RD_RESP: begin
                    if (rd_rdy) begin
                        state_d = IDLE_ADDR;
                    end
                end
                default: begin
                    state_d = IDLE_ADDR;
                end
            endcase
        end
    end

    assign addr_rdy = live_q && (state_q == IDLE_ADDR);
    assign cmd_rdy  = live_q && (state_q == GET_CMD);
    assign wr_rdy   = live_q && (state_q == GET_WR);
    assign rd_val   = live_q && (state_q == RD_RESP);

    sp_ram #(
        .A (A),
        .W (W)
    ) u_ram (
        .clk_i   (clk),
        .rst_i   (rst),
        .we_i    (ram_we),
        .re_i    (ram_re),
        .addr_i  (addr_q),
        .wdata_i (wr_data),
        .rdata_o (rd_data)
    );

endmodule

// File: tb/tb_mem_slave.sv
// Scoreboard bench for mem_slave: RL=2 and RL=0 instances.
// Inputs go to the instance chosen by sel; the other sees idle vals.
module tb_mem_slave;

    localparam int A = 4;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         sel;
    logic [A-1:0] addr;
    logic         addr_val, cmd, cmd_val, wr_val, rd_rdy;
    logic [W-1:0] wr_data;

    logic         ar0, cr0, wr0, rv0, ar1, cr1, wr1, rv1;
    logic [W-1:0] rd0, rd1;
    logic         m_ar, m_cr, m_wr, m_rv;
    logic [W-1:0] m_rd;

    int n_vec = 0;
    int n_err = 0;

    logic [W-1:0] sb [$];
    logic [W-1:0] mdl [2][16];

    always #5 clk = ~clk;

    mem_slave #(.A(A), .W(W), .RL(2)) dut0 (
        .clk(clk), .rst(rst),
        .addr(addr), .addr_val(addr_val & ~sel), .addr_rdy(ar0),
        .cmd(cmd), .cmd_val(cmd_val & ~sel), .cmd_rdy(cr0),
        .wr_data(wr_data), .wr_val(wr_val & ~sel), .wr_rdy(wr0),
        .rd_data(rd0), .rd_val(rv0), .rd_rdy(rd_rdy & ~sel)
    );

    mem_slave #(.A(A), .W(W), .RL(0)) dut1 (
        .clk(clk), .rst(rst),
        .addr(addr), .addr_val(addr_val & sel), .addr_rdy(ar1),
        .cmd(cmd), .cmd_val(cmd_val & sel), .cmd_rdy(cr1),
        .wr_data(wr_data), .wr_val(wr_val & sel), .wr_rdy(wr1),
        .rd_data(rd1), .rd_val(rv1), .rd_rdy(rd_rdy & sel)
    );

    assign m_ar = sel ? ar1 : ar0;
    assign m_cr = sel ? cr1 : cr0;
    assign m_wr = sel ? wr1 : wr0;
    assign m_rv = sel ? rv1 : rv0;
    assign m_rd = sel ? rd1 : rd0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic rdy_of(input int ph);
        case (ph)
            0:       return m_ar;
            1:       return m_cr;
            2:       return m_wr;
            default: return m_rv;
        endcase
    endfunction

    // Raise one phase's val, wait for rdy, let one edge transfer it.
    task automatic phase(input int ph);
        int t;
        t = 0;
        case (ph)
            0:       addr_val = 1'b1;
            1:       cmd_val  = 1'b1;
            2:       wr_val   = 1'b1;
            default: rd_rdy   = 1'b1;
        endcase
        while (!rdy_of(ph) && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("hs_timeout", 32'(t >= 50), 32'd0);
        @(negedge clk);
        addr_val = 1'b0;
        cmd_val  = 1'b0;
        wr_val   = 1'b0;
        rd_rdy   = 1'b0;
    endtask

    task automatic do_write(input logic [A-1:0] a, input logic [W-1:0] d);
        addr = a;
        phase(0);
        cmd = 1'b1;
        phase(1);
        wr_data = d;
        phase(2);
        mdl[sel][a] = d;
        chk("wr_idle", 32'(m_ar), 32'd1);
    endtask

    task automatic do_read(input logic [A-1:0] a, input int stall);
        int           lat;
        logic [W-1:0] exp;
        addr = a;
        phase(0);
        cmd = 1'b0;
        phase(1);
        sb.push_back(mdl[sel][a]);
        lat = 0;
        while (!m_rv && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        chk("rd_lat", 32'(lat), sel ? 32'd0 : 32'd2);
        exp = sb.pop_front();
        for (int i = 0; i < stall; i++) begin
            chk("rd_hold_val", 32'(m_rv), 32'd1);
            chk("rd_hold_data", 32'(m_rd), 32'(exp));
            @(negedge clk);
        end
        chk("rd_data", 32'(m_rd), 32'(exp));
        rd_rdy = 1'b1;
        @(negedge clk);
        rd_rdy = 1'b0;
        chk("rd_done_val", 32'(m_rv), 32'd0);
        chk("rd_idle", 32'(m_ar), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; sel = 1'b0; addr = '0; cmd = 1'b0;
        addr_val = 1'b0; cmd_val = 1'b0; wr_val = 1'b0;
        rd_rdy = 1'b0; wr_data = '0;
        repeat (2) @(negedge clk);
        chk("rst_outs", {28'd0, ar0, cr0, wr0, rv0}, 32'd0);
        chk("rst_rdata", 32'(rd0), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ardy", 32'(m_ar), 32'd1);

        do_write(4'd3, 8'hA5);
        do_read(4'd3, 0);
        do_read(4'd3, 5);

        // Write held in GET_WR while other phases toggle.
        addr = 4'd7;
        phase(0);
        cmd = 1'b1;
        phase(1);
        for (int i = 0; i < 3; i++) begin
            wr_data  = 8'($urandom);
            addr     = 4'($urandom);
            cmd      = 1'b0;
            addr_val = ~addr_val;
            cmd_val  = ~cmd_val;
            @(negedge clk);
            chk("gw_hold", {29'd0, m_ar, m_cr, m_wr}, 32'd1);
        end
        addr_val = 1'b0;
        cmd_val  = 1'b0;
        wr_data  = 8'h5A;
        phase(2);
        mdl[0][7] = 8'h5A;
        do_read(4'd7, 0);
        do_read(4'd3, 0);

        // Reset asserted mid-cycle while waiting in GET_WR.
        addr = 4'd3;
        phase(0);
        cmd = 1'b1;
        phase(1);
        chk("pre_rst_wrdy", 32'(m_wr), 32'd1);
        wr_data = 8'hFF;
        wr_val  = 1'b1;
        #2 rst = 1'b1;
        #1;
        chk("arst_outs", {28'd0, m_ar, m_cr, m_wr, m_rv}, 32'd0);
        chk("arst_rdata", 32'(m_rd), 32'd0);
        @(negedge clk);
        wr_val = 1'b0;
        rst    = 1'b0;
        @(negedge clk);
        chk("rst2_ardy", 32'(m_ar), 32'd1);
        do_read(4'd3, 0);

        // Zero-latency instance.
        sel = 1'b1;
        @(negedge clk);
        do_write(4'd15, 8'h01);
        do_read(4'd15, 0);
        sel = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 16; i++) begin
            do_write(4'(i), 8'(i * 3));
        end
        for (int i = 0; i < 16; i++) begin
            do_read(4'(i), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule
